// File: rtl/rom_port_sched_if.sv
// rom_port_sched_if
//   Bundles the ROM port, the data-side read port, the branch redirect and
//   the decoded-instruction handshake of rom_port_sched.
//   slave  : view taken by rom_port_sched (drives rom_*_o, d*_o, inst_*_o).
//   master : view taken by the surrounding core / environment.
//   Signals:
//     rom_ce_o, rom_addr_o[31:0]   ROM chip enable and byte address
//     rom_inst_i[31:0]             ROM data, combinational in the same cycle
//     dreq_i, daddr_i[31:0]        data-side read request and byte address
//     dack_o, ddata_o[31:0]        data read grant and zero-latency result
//     branch_flag_i, branch_target_i[31:0]  fetch redirect
//     inst_valid_o, inst_o[31:0], inst_pc_o[31:0], inst_ready_i  ID handshake
interface rom_port_sched_if;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        dreq_i;
  logic [31:0] daddr_i;
  logic        dack_o;
  logic [31:0] ddata_o;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  modport slave (
    output rom_ce_o, rom_addr_o, dack_o, ddata_o,
           inst_valid_o, inst_o, inst_pc_o,
    input  rom_inst_i, dreq_i, daddr_i, branch_flag_i, branch_target_i,
           inst_ready_i
  );

  modport master (
    input  rom_ce_o, rom_addr_o, dack_o, ddata_o,
           inst_valid_o, inst_o, inst_pc_o,
    output rom_inst_i, dreq_i, daddr_i, branch_flag_i, branch_target_i,
           inst_ready_i
  );
endinterface

// File: rtl/rom_port_sched.sv
// rom_port_sched
//   Shares the single combinational instruction-ROM port between the fetch
//   path (PC generator + prefetch queue feeding ID) and a data-side reader.
//   Data reads win arbitration unless fetch has been starved for
//   STARVE_LIMIT consecutive data grants. A branch flushes the queue and
//   redirects the PC.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-low reset
//     bus  rom_port_sched_if.slave (ROM, data, branch and ID signals)
module rom_port_sched #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          QDEPTH       = 4,
  parameter int          STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  rom_port_sched_if.slave bus
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
  localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);

  logic          started_q;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   q_inst [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];

  logic fetch_want, dgnt, fgnt, head_vld, pop;

  // Arbitration. fetch_want looks only at registered occupancy, so a pop in
  // the same cycle never opens a slot for a fetch (no ready-to-ce path).
  always_comb begin
    head_vld   = (cnt_q != '0);
    pop        = head_vld && bus.inst_ready_i;
    fetch_want = started_q && (cnt_q < QFULL) && !bus.branch_flag_i;
    dgnt       = started_q && bus.dreq_i && !(fetch_want && (starve_q == SLIM));
    fgnt       = !dgnt && fetch_want;
  end

  always_comb begin
    bus.rom_ce_o     = dgnt || fgnt;
    bus.rom_addr_o   = dgnt ? bus.daddr_i : (fgnt ? pc_q : 32'h0);
    bus.dack_o       = dgnt;
    bus.ddata_o      = dgnt ? bus.rom_inst_i : 32'h0;
    bus.inst_valid_o = head_vld;
    bus.inst_o       = head_vld ? q_inst[rd_q] : 32'h0;
    bus.inst_pc_o    = head_vld ? q_pc[rd_q] : 32'h0;
  end

  always_comb begin
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    starve_d = starve_q;
    // The starvation count only grows while fetch actually wanted the port.
    if (dgnt)
      starve_d = fetch_want ? (starve_q + SW'(1)) : '0;
    else if (fgnt)
      starve_d = '0;
    if (bus.branch_flag_i) begin
      // Flush overrides any push/pop of this cycle.
      pc_d  = bus.branch_target_i & ~32'h3;
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
    end else begin
      if (fgnt) begin
        pc_d = pc_q + 32'd4;
        wr_d = wr_q + 1'b1;
      end
      if (pop)
        rd_d = rd_q + 1'b1;
      case ({fgnt, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_q <= 1'b0;
      pc_q      <= RESET_PC;
      cnt_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      starve_q  <= '0;
    end else begin
      started_q <= 1'b1;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      starve_q  <= starve_d;
    end
  end

  // Queue storage needs no reset: reads are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (fgnt) begin
      q_inst[wr_q] <= bus.rom_inst_i;
      q_pc[wr_q]   <= pc_q;
    end
  end
endmodule

// File: doc/rom_port_sched.md
Name: rom_port_sched

Overview:
- Sequences and shares the single combinational instruction-ROM port between two requesters: the instruction-fetch path (PC generator plus prefetch queue) and a data-side read requester that reads constants from the code region.
- Sits between the ROM and the ID stage.
- Data reads get priority, with a starvation guard for fetch.
- Branch redirects flush the prefetch queue.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- QDEPTH, 4, prefetch queue entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive data grants after which a pending fetch gets one cycle.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- rom_ce_o  output  1  ROM chip enable
- rom_addr_o  output  32  ROM byte address
- rom_inst_i  input  32  ROM read data, valid combinationally in the same cycle
- dreq_i  input  1  data-side read request
- daddr_i  input  32  data-side byte address
- dack_o  output  1  data read granted this cycle
- ddata_o  output  32  data read result
- branch_flag_i  input  1  redirect fetch
- branch_target_i  input  32  redirect address
- inst_valid_o  output  1  queue head valid
- inst_o  output  32  head instruction
- inst_pc_o  output  32  head PC
- inst_ready_i  input  1  ID accepts head

Behaviour:
- Reset (rst=0, asynchronous):
  - pc = RESET_PC; queue empty (count=0); starvation counter = 0; started flag = 0.
  - Outputs: rom_ce_o=0, rom_addr_o=0, dack_o=0, ddata_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0.
- First edge after rst deasserts: started = 1. No grant is issued in that first cycle.
- Arbitration, each cycle with started=1, combinational:
  - fetch_want = (count < QDEPTH) && !branch_flag_i.
  - Data grant if dreq_i && !(fetch_want && starve_cnt == STARVE_LIMIT).
  - Otherwise fetch grant if fetch_want.
  - Otherwise idle.
- Data grant:
  - rom_ce_o=1, rom_addr_o=daddr_i, dack_o=1, ddata_o=rom_inst_i (same cycle, zero latency).
  - daddr_i[1:0] is passed through unchanged; the ROM ignores those bits.
  - starve_cnt increments at the edge if fetch_want, else clears.
- Fetch grant:
  - rom_ce_o=1, rom_addr_o=pc, dack_o=0.
  - At the edge: push {pc, rom_inst_i}; pc <= pc+4 (wraps 32'hFFFFFFFC -> 0); starve_cnt <= 0.
- Idle: rom_ce_o=0, rom_addr_o=0, dack_o=0, ddata_o=0.
- Queue:
  - inst_valid_o = (count != 0); inst_o and inst_pc_o show the head entry, or 0 when empty.
  - Pop at the edge when inst_valid_o && inst_ready_i.
  - Push and pop in the same cycle leave count unchanged.
  - Full queue (count == QDEPTH): no fetch grant, even if a pop occurs that cycle. No combinational ready-to-ce path.
- Branch (branch_flag_i=1 at an edge):
  - Queue cleared (count=0, pointers reset), overriding any push or pop that cycle.
  - pc <= {branch_target_i[31:2], 2'b00}.
  - No fetch grant in the branch cycle.
  - A data grant in the same cycle completes normally.
  - inst_valid_o=0 in the following cycle. The first post-branch instruction is valid 2 cycles after the branch edge if data is not contending.
- The data requester holds dreq_i/daddr_i until dack_o. Each cycle with dack_o=1 completes exactly one read.
- Throughput: with no contention and ID always ready, one instruction per cycle.

Test Plan:
- Sequential fetch: ROM word n = 32'h1000_0000+n, RESET_PC=0, inst_ready_i=1, release rst -> inst_pc_o sequence 0,4,8,... and inst_o = 1000_0000, 1000_0001, ... on consecutive cycles; rom_ce_o=0 in the first cycle after release.
- Backpressure: inst_ready_i=0 -> exactly 4 fetches, then rom_ce_o=0 and pc=16. Raise ready for 1 cycle -> one pop. The refetch at pc=16 occurs the cycle after the pop.
- Branch: branch_flag_i=1 with target 32'h0000_0042 while the queue holds 3 entries -> inst_valid_o=0 next cycle, next fetch address 32'h40, and no stale PCs (4/8/12) ever appear after the flush.
- Data contention: dreq_i held 2 cycles with daddr_i=32'h20 -> dack_o=1 both cycles, ddata_o = ROM word 8, rom_addr_o=32'h20, and fetch pc frozen for those cycles.
- Starvation guard: dreq_i held continuously with queue empty -> grant pattern D,D,D,D,F repeating; one instruction is enqueued every 5th cycle.
- Async reset mid-operation: drop rst between edges with the queue half full -> all outputs go to 0 immediately (before the next edge); after release, fetch restarts at RESET_PC.
